// File: rtl/cnn_pkg.sv
// Shared definitions for the MAC array address generators and write-back.
// Holds the memory address width and the write-back FSM state encodings.
package cnn_pkg;

    localparam int ADR_W = 8;

    typedef enum logic [2:0] {
        WB_IDLE  = 3'd0,
        WB_WAIT  = 3'd1,
        WB_READ  = 3'd2,
        WB_LATCH = 3'd3,
        WB_WRITE = 3'd4
    } wb_state_e;

endpackage

// File: rtl/mac_result_writer_if.sv
// MAC-side pop port plus memory write port of the result writer.
// master: the writer (pops MACs, drives memory); slave: MACs and memory.
interface mac_result_writer_if
    import cnn_pkg::*;
#(
    parameter int macCount  = 4,
    parameter int dataWidth = 16
);

    logic [macCount-1:0]           macDone;
    logic [macCount*dataWidth-1:0] macData;
    logic [macCount-1:0]           macRead;
    logic [ADR_W-1:0]              memAdr;
    logic [dataWidth-1:0]          memData;
    logic                          memWe;

    modport master (
        input  macDone,
        input  macData,
        output macRead,
        output memAdr,
        output memData,
        output memWe
    );

    modport slave (
        output macDone,
        output macData,
        input  macRead,
        input  memAdr,
        input  memData,
        input  memWe
    );

endinterface

// File: rtl/mac_result_writer_wb_index_counter.sv
// Nested result/MAC index counter: resCnt inner, sel outer.
// Ports: clk, rst, inc (advance), clr (zero both), sel, last (final slot).
module wb_index_counter #(
    parameter int macCount  = 4,
    parameter int resPerMac = 4,
    localparam int SEL_W    = $clog2(macCount) + 1,
    localparam int RES_W    = $clog2(resPerMac) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             res_last;
    logic             sel_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            res_q <= '0;
        end else begin
            sel_q <= sel_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        res_last = (res_q == RES_W'(resPerMac - 1));
        sel_last = (sel_q == SEL_W'(macCount - 1));
        sel_d    = sel_q;
        res_d    = res_q;
        if (clr) begin
            sel_d = '0;
            res_d = '0;
        end else if (inc) begin
            if (res_last) begin
                res_d = '0;
                // Wrap sel after the final MAC so a stale index never
                // points past the array between passes.
                sel_d = sel_last ? '0 : sel_q + SEL_W'(1);
            end else begin
                res_d = res_q + RES_W'(1);
            end
        end
    end

    assign sel  = sel_q;
    assign last = res_last && sel_last;

endmodule

// File: rtl/mac_result_writer.sv
// Write-back end of the MAC array: drains resPerMac results per MAC into memory.
// Ports: clk, rst, start, adrZ (base), busy, wbDone, bus (MAC pop + mem write).
module mac_result_writer
    import cnn_pkg::*;
#(
    parameter int macCount  = 4,
    parameter int resPerMac = 4,
    parameter int dataWidth = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADR_W-1:0]   adrZ,
    output logic               busy,
    output logic               wbDone,
    mac_result_writer_if.master bus
);

    localparam int SEL_W = $clog2(macCount) + 1;

    wb_state_e state_q, state_d;

    logic [ADR_W-1:0]     adr_base_q, adr_base_d;
    logic [ADR_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [macCount-1:0]  mac_read_q, mac_read_d;
    logic [ADR_W-1:0]     mem_adr_q, mem_adr_d;
    logic [dataWidth-1:0] mem_data_q, mem_data_d;
    logic                 mem_we_q, mem_we_d;
    logic                 busy_q, busy_d;
    logic                 wb_done_q, wb_done_d;

    logic [SEL_W-1:0]     sel;
    logic                 last;
    logic                 cnt_inc;
    logic                 cnt_clr;

    logic                 cur_done;
    logic [dataWidth-1:0] cur_data;
    logic [macCount-1:0]  sel_hot;

    wb_index_counter #(
        .macCount  (macCount),
        .resPerMac (resPerMac)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .sel  (sel),
        .last (last)
    );

    // Select the current MAC's done flag and data slice; sel_hot is
    // the one-hot pop strobe so macRead can never be multi-hot.
    always_comb begin
        cur_done = 1'b0;
        cur_data = '0;
        sel_hot  = '0;
        for (int i = 0; i < macCount; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_done   = bus.macDone[i];
                cur_data   = bus.macData[i*dataWidth +: dataWidth];
                sel_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WB_IDLE;
            adr_base_q <= '0;
            wr_cnt_q   <= '0;
            mac_read_q <= '0;
            mem_adr_q  <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            wb_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_base_q <= adr_base_d;
            wr_cnt_q   <= wr_cnt_d;
            mac_read_q <= mac_read_d;
            mem_adr_q  <= mem_adr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            wb_done_q  <= wb_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE:  if (start) state_d = WB_WAIT;
            WB_WAIT:  if (cur_done) state_d = WB_READ;
            WB_READ:  state_d = WB_LATCH;
            WB_LATCH: state_d = WB_WRITE;
            WB_WRITE: state_d = last ? WB_IDLE : WB_WAIT;
            default:  state_d = WB_IDLE;
        endcase
    end

    // Outputs are registered, so each strobe is set on the edge that
    // enters the state it belongs to (macRead in READ, memWe in WRITE).
    always_comb begin
        adr_base_d = adr_base_q;
        wr_cnt_d   = wr_cnt_q;
        mac_read_d = '0;
        mem_adr_d  = mem_adr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        busy_d     = busy_q;
        wb_done_d  = wb_done_q;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                if (start) begin
                    adr_base_d = adrZ;
                    wr_cnt_d   = '0;
                    cnt_clr    = 1'b1;
                    busy_d     = 1'b1;
                    wb_done_d  = 1'b0;
                end
            end
            WB_WAIT: begin
                if (cur_done) mac_read_d = sel_hot;
            end
            WB_READ: begin
                // MAC data becomes valid during LATCH.
            end
            WB_LATCH: begin
                mem_data_d = cur_data;
                mem_adr_d  = adr_base_q + wr_cnt_q;
                mem_we_d   = 1'b1;
            end
            WB_WRITE: begin
                wr_cnt_d = wr_cnt_q + 8'd1;
                cnt_inc  = 1'b1;
                if (last) begin
                    busy_d    = 1'b0;
                    wb_done_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.macRead = mac_read_q;
    assign bus.memAdr  = mem_adr_q;
    assign bus.memData = mem_data_q;
    assign bus.memWe   = mem_we_q;
    assign busy        = busy_q;
    assign wbDone      = wb_done_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// Scoreboard bench for mac_result_writer (4x4 and 1x1 configurations).
// Expected writes are queued at stimulus time; monitors pop on memWe.
module tb_mac_result_writer;

    typedef struct {
        logic [7:0]  adr;
        logic [15:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] adrZ = 8'h00;
    logic       busy, wbDone;
    logic       start1 = 1'b0;
    logic [7:0] adrZ1 = 8'h00;
    logic       busy1, wbDone1;

    mac_result_writer_if #(.macCount(4), .dataWidth(16)) bus ();
    mac_result_writer_if #(.macCount(1), .dataWidth(16)) bus1 ();

    mac_result_writer #(
        .macCount(4), .resPerMac(4), .dataWidth(16)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .adrZ(adrZ),
        .busy(busy), .wbDone(wbDone), .bus(bus)
    );

    mac_result_writer #(
        .macCount(1), .resPerMac(1), .dataWidth(16)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .adrZ(adrZ1),
        .busy(busy1), .wbDone(wbDone1), .bus(bus1)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  nwr = 0;
    int  nrd = 0;
    int  nwr1 = 0;
    int  prev_we = -1;
    int  first_we = -1;
    int  start_cyc = 0;
    bit  gap_chk = 1'b0;
    int  exp_ptr [4];
    int  exp_ptr1 = 0;
    int  mptr [4];
    int  mptr1 = 0;
    wr_t exp_q[$];
    wr_t exp1_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mk_data(input int m, input int r);
        return 16'hA000 | 16'(m << 8) | 16'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MAC models: a pop presents the next result one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mptr[i] <= 0;
            mptr1 <= 0;
            bus.macData  <= '0;
            bus1.macData <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.macRead[i]) begin
                    bus.macData[i*16 +: 16] <= mk_data(i, mptr[i]);
                    mptr[i] <= mptr[i] + 1;
                end
            end
            if (bus1.macRead[0]) begin
                bus1.macData <= mk_data(0, mptr1);
                mptr1 <= mptr1 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.memWe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got adr %0h expected none",
                             bus.memAdr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_adr", 32'(bus.memAdr), 32'(e.adr));
                    chk("wr_data", 32'(bus.memData), 32'(e.data));
                end
                if (gap_chk && prev_we >= 0)
                    chk("wr_gap", 32'(cyc - prev_we), 32'd4);
                chk("rd_we_overlap", 32'(bus.macRead), 32'd0);
                if (first_we < 0) first_we = cyc;
                prev_we = cyc;
                nwr++;
            end
            if (bus.macRead != 4'b0000) begin
                nrd++;
                chk("rd_onehot", 32'($onehot(bus.macRead)), 32'd1);
            end
            if (bus1.memWe) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write1: got adr %0h expected none",
                             bus1.memAdr);
                end else begin
                    wr_t e;
                    e = exp1_q.pop_front();
                    chk("wr1_adr", 32'(bus1.memAdr), 32'(e.adr));
                    chk("wr1_data", 32'(bus1.memData), 32'(e.data));
                end
                nwr1++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_ptr[i] = 0;
        exp_ptr1 = 0;
    endtask

    task automatic push_pass(input logic [7:0] base, input int limit);
        int idx;
        idx = 0;
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < 4; r++) begin
                if (idx < limit) begin
                    wr_t e;
                    e.adr  = base + 8'(idx);
                    e.data = mk_data(m, exp_ptr[m]);
                    exp_ptr[m]++;
                    exp_q.push_back(e);
                end
                idx++;
            end
        end
    endtask

    task automatic pulse_start(input logic [7:0] a);
        nwr = 0;
        nrd = 0;
        prev_we = -1;
        first_we = -1;
        start = 1'b1;
        adrZ = a;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget,
                             input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (which ? (wbDone1 && !busy1) : (wbDone && !busy)) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got busy expected done", name);
        end
    endtask

    task automatic wait_writes(input int n, input int budget,
                               input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (nwr >= n) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got %0d writes expected %0d",
                     name, nwr, n);
        end
    endtask

    initial begin
        bus.macDone  = 4'b0000;
        bus1.macDone = 1'b0;
        for (int i = 0; i < 4; i++) exp_ptr[i] = 0;

        // Reset state
        tick();
        chk("rst_macRead", 32'(bus.macRead), 32'd0);
        chk("rst_memAdr", 32'(bus.memAdr), 32'd0);
        chk("rst_memData", 32'(bus.memData), 32'd0);
        chk("rst_memWe", 32'(bus.memWe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wbDone", 32'(wbDone), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        do_reset();

        // 1: base 0x40, all MACs ready
        bus.macDone = 4'b1111;
        gap_chk = 1'b1;
        push_pass(8'h40, 16);
        pulse_start(8'h40);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(1'b0, 100, "t1");
        chk("t1_latency", 32'(first_we - start_cyc), 32'd4);
        chk("t1_done_cycle", 32'(cyc - prev_we), 32'd1);
        chk("t1_nwr", 32'(nwr), 32'd16);
        chk("t1_queue", 32'(exp_q.size()), 32'd0);

        // 2: address wrap from 0xFE
        push_pass(8'hFE, 16);
        pulse_start(8'hFE);
        wait_done(1'b0, 100, "t2");
        chk("t2_nwr", 32'(nwr), 32'd16);
        chk("t2_queue", 32'(exp_q.size()), 32'd0);
        gap_chk = 1'b0;

        // 3: only MAC0 ready, stall in WAIT
        do_reset();
        bus.macDone = 4'b0001;
        push_pass(8'h20, 16);
        pulse_start(8'h20);
        wait_writes(4, 40, "t3a");
        repeat (10) tick();
        chk("t3_stall_nwr", 32'(nwr), 32'd4);
        chk("t3_stall_busy", 32'(busy), 32'd1);
        chk("t3_stall_rd", 32'(bus.macRead), 32'd0);
        bus.macDone = 4'b0011;
        tick();
        chk("t3_read_mac1", 32'(bus.macRead), 32'b0010);
        wait_writes(8, 40, "t3b");
        bus.macDone = 4'b1111;
        wait_done(1'b0, 100, "t3");
        chk("t3_nwr", 32'(nwr), 32'd16);
        chk("t3_queue", 32'(exp_q.size()), 32'd0);

        // 4: start while busy ignored, start during final WRITE ignored
        push_pass(8'h50, 16);
        pulse_start(8'h50);
        wait_writes(4, 40, "t4a");
        start = 1'b1;
        adrZ = 8'h80;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.memWe && bus.memAdr == 8'h5F) break;
            tick();
        end
        chk("t4_last_we", 32'(bus.memWe), 32'd1);
        start = 1'b1;
        adrZ = 8'h80;
        tick();
        start = 1'b0;
        chk("t4_done_busy", 32'(busy), 32'd0);
        chk("t4_done_flag", 32'(wbDone), 32'd1);
        repeat (6) tick();
        chk("t4_no_restart", 32'(busy), 32'd0);
        chk("t4_nwr", 32'(nwr), 32'd16);
        chk("t4_queue", 32'(exp_q.size()), 32'd0);

        // 5: reset during LATCH of 6th result
        do_reset();
        push_pass(8'h30, 5);
        pulse_start(8'h30);
        for (int i = 0; i < 60; i++) begin
            if (nrd >= 6) break;
            tick();
        end
        chk("t5_nrd", 32'(nrd), 32'd6);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_macRead", 32'(bus.macRead), 32'd0);
        chk("t5_memAdr", 32'(bus.memAdr), 32'd0);
        chk("t5_memData", 32'(bus.memData), 32'd0);
        chk("t5_memWe", 32'(bus.memWe), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_wbDone", 32'(wbDone), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        chk("t5_nwr", 32'(nwr), 32'd5);
        chk("t5_queue", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) exp_ptr[i] = 0;
        push_pass(8'h10, 16);
        pulse_start(8'h10);
        wait_done(1'b0, 100, "t5");
        chk("t5_nwr2", 32'(nwr), 32'd16);
        chk("t5_queue2", 32'(exp_q.size()), 32'd0);

        // 6: single MAC, single result; sticky wbDone
        bus1.macDone = 1'b1;
        begin
            wr_t e;
            e.adr = 8'h77;
            e.data = mk_data(0, 0);
            exp1_q.push_back(e);
        end
        start1 = 1'b1;
        adrZ1 = 8'h77;
        tick();
        start1 = 1'b0;
        wait_done(1'b1, 30, "t6a");
        chk("t6_nwr", 32'(nwr1), 32'd1);
        repeat (5) tick();
        chk("t6_sticky", 32'(wbDone1), 32'd1);
        begin
            wr_t e;
            e.adr = 8'h78;
            e.data = mk_data(0, 1);
            exp1_q.push_back(e);
        end
        start1 = 1'b1;
        adrZ1 = 8'h78;
        tick();
        start1 = 1'b0;
        chk("t6_cleared", 32'(wbDone1), 32'd0);
        chk("t6_busy", 32'(busy1), 32'd1);
        wait_done(1'b1, 30, "t6b");
        chk("t6_nwr2", 32'(nwr1), 32'd2);
        chk("t6_queue", 32'(exp1_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
